// File: rtl/sr_chk_pkg.sv
// Shared types and helpers for the SR flip-flop checker: model state
// encodings, the default counter width and the model next-state function.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        ST_UNK = 2'b00,
        ST_Q0  = 2'b01,
        ST_Q1  = 2'b10,
        ST_BAD = 2'b11
    } state_e;

    localparam int CNT_W_DEFAULT = 8;

    // 00 holds whatever the model believed, including UNK and BAD.
    function automatic state_e next_state(input state_e cur, input logic s, input logic r);
        state_e nxt;
        case ({s, r})
            2'b10:   nxt = ST_Q1;
            2'b01:   nxt = ST_Q0;
            2'b11:   nxt = ST_BAD;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_chk_sat_cnt.sv
// Saturating event counter: holds at all-ones, synchronous clear wins over
// the old value but the same-edge increment still lands (clear then count).
module sr_chk_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? ONE : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sr_ff_checker.sv
// Run-time monitor beside an SR flop: models its state, compares q (and qbar
// when SR_CHK_COMPLEMENT_EN is defined), flags s=r=1 and counts events.
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    input  logic             clr,
    output logic             model_q,
    output logic             known,
    output logic             illegal,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mismatch_q, mismatch_d;
    logic   err_sticky_q, err_sticky_d;
    logic   exp_q;

`ifndef SR_CHK_COMPLEMENT_EN
    logic unused_qbar;
    assign unused_qbar = qbar;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = next_state(state_q, s, r);
        illegal_d  = s & r;
        mismatch_d = 1'b0;
        exp_q      = (state_q == ST_Q1);
        // Compare uses the pre-edge model state; q here is the flop's pre-edge output.
        if ((state_q == ST_Q0) || (state_q == ST_Q1)) begin
            if (q !== exp_q) mismatch_d = 1'b1;
`ifdef SR_CHK_COMPLEMENT_EN
            if (qbar !== ~exp_q) mismatch_d = 1'b1;
`endif
        end
        err_sticky_d = (clr ? 1'b0 : err_sticky_q) | illegal_d | mismatch_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNK;
            illegal_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_q    <= illegal_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    sr_chk_sat_cnt #(.W(CNT_W)) u_illegal_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (illegal_d),
        .cnt (illegal_cnt)
    );

    sr_chk_sat_cnt #(.W(CNT_W)) u_mismatch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (mismatch_d),
        .cnt (mismatch_cnt)
    );

    assign model_q    = (state_q == ST_Q1);
    assign known      = (state_q == ST_Q0) || (state_q == ST_Q1);
    assign illegal    = illegal_q;
    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed bench for sr_ff_checker with a behavioural SR flop attached and
// override hooks to corrupt q/qbar; honours SR_CHK_COMPLEMENT_EN.
module tb_sr_ff_checker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s = 1'b0;
    logic             r = 1'b0;
    logic             clr = 1'b0;
    logic             q;
    logic             qbar;
    logic             model_q;
    logic             known;
    logic             illegal;
    logic             mismatch;
    logic             err_sticky;
    logic [CNT_W-1:0] illegal_cnt;
    logic [CNT_W-1:0] mismatch_cnt;

    logic ff_q, ff_qbar;
    logic frc_q_en = 1'b0, frc_q_val = 1'b0;
    logic frc_qb_en = 1'b0, frc_qb_val = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference SR flop; 11 drives both outputs high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= 1'b0; ff_qbar <= 1'b1;
        end else begin
            case ({s, r})
                2'b10:   begin ff_q <= 1'b1; ff_qbar <= 1'b0; end
                2'b01:   begin ff_q <= 1'b0; ff_qbar <= 1'b1; end
                2'b11:   begin ff_q <= 1'b1; ff_qbar <= 1'b1; end
                default: ;
            endcase
        end
    end

    assign q    = frc_q_en  ? frc_q_val  : ff_q;
    assign qbar = frc_qb_en ? frc_qb_val : ff_qbar;

    sr_ff_checker #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (s),
        .r            (r),
        .q            (q),
        .qbar         (qbar),
        .clr          (clr),
        .model_q      (model_q),
        .known        (known),
        .illegal      (illegal),
        .mismatch     (mismatch),
        .err_sticky   (err_sticky),
        .illegal_cnt  (illegal_cnt),
        .mismatch_cnt (mismatch_cnt)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s = 1'b0; r = 1'b0; clr = 1'b0;
        #2;
        checks++; if (known !== 1'b0) begin errors++; $display("FAIL rst_known: got %b want 0", known); end
        checks++; if (model_q !== 1'b0) begin errors++; $display("FAIL rst_model_q: got %b want 0", model_q); end
        checks++; if ({illegal, mismatch, err_sticky} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {illegal, mismatch, err_sticky}); end
        checks++; if ({illegal_cnt, mismatch_cnt} !== 16'h0000) begin errors++; $display("FAIL rst_cnts: got %h want 0000", {illegal_cnt, mismatch_cnt}); end
        #1 rst = 1'b0;
        repeat (3) cycle();
        checks++; if (known !== 1'b0) begin errors++; $display("FAIL idle_known: got %b want 0", known); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL idle_mismatch: got %b want 0", mismatch); end
        checks++; if ({illegal_cnt, mismatch_cnt} !== 16'h0000) begin errors++; $display("FAIL idle_cnts: got %h want 0000", {illegal_cnt, mismatch_cnt}); end
    endtask

    task automatic test_set();
        s = 1'b1; cycle();
        checks++; if ({known, model_q} !== 2'b11) begin errors++; $display("FAIL set_state: got known/model_q %b want 11", {known, model_q}); end
        s = 1'b0; cycle();
        cycle();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL set_mismatch: got %b want 0", mismatch); end
        checks++; if (mismatch_cnt !== 8'd0) begin errors++; $display("FAIL set_mcnt: got %0d want 0", mismatch_cnt); end
    endtask

    task automatic test_mismatch();
        logic [7:0] exp_mcnt;
        frc_q_en = 1'b1; frc_q_val = 1'b0;
        cycle();
        frc_q_en = 1'b0;
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL q_mismatch_pulse: got %b want 1", mismatch); end
        checks++; if (mismatch_cnt !== 8'd1) begin errors++; $display("FAIL q_mcnt: got %0d want 1", mismatch_cnt); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL q_sticky: got %b want 1", err_sticky); end
        cycle();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL q_pulse_width: got %b want 0", mismatch); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL q_sticky_hold: got %b want 1", err_sticky); end
        // Move to Q0 so forcing qbar low is a complement error.
        r = 1'b1; cycle();
        r = 1'b0; cycle();
        checks++; if ({known, model_q, mismatch} !== 3'b100) begin errors++; $display("FAIL q0_state: got %b want 100", {known, model_q, mismatch}); end
        frc_qb_en = 1'b1; frc_qb_val = 1'b0;
        cycle();
        frc_qb_en = 1'b0;
`ifdef SR_CHK_COMPLEMENT_EN
        exp_mcnt = 8'd2;
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL qbar_pulse: got %b want 1", mismatch); end
`else
        exp_mcnt = 8'd1;
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL qbar_ignored: got %b want 0", mismatch); end
`endif
        checks++; if (mismatch_cnt !== exp_mcnt) begin errors++; $display("FAIL qbar_mcnt: got %0d want %0d", mismatch_cnt, exp_mcnt); end
    endtask

    task automatic test_illegal();
        logic [7:0] mcnt0;
        mcnt0 = mismatch_cnt;
        s = 1'b1; r = 1'b1; cycle();
        s = 1'b0; r = 1'b0;
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse: got %b want 1", illegal); end
        checks++; if (illegal_cnt !== 8'd1) begin errors++; $display("FAIL ill_cnt: got %0d want 1", illegal_cnt); end
        checks++; if (known !== 1'b0) begin errors++; $display("FAIL ill_known: got %b want 0", known); end
        frc_q_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frc_q_val = i[0];
            frc_qb_en = i[1]; frc_qb_val = i[0];
            cycle();
        end
        frc_q_en = 1'b0; frc_qb_en = 1'b0;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_pulse_width: got %b want 0", illegal); end
        checks++; if ({known, mismatch} !== 2'b00) begin errors++; $display("FAIL bad_no_compare: got known/mismatch %b want 00", {known, mismatch}); end
        checks++; if (mismatch_cnt !== mcnt0) begin errors++; $display("FAIL bad_mcnt: got %0d want %0d", mismatch_cnt, mcnt0); end
        r = 1'b1; cycle();
        r = 1'b0;
        checks++; if ({known, model_q} !== 2'b10) begin errors++; $display("FAIL bad_to_q0: got known/model_q %b want 10", {known, model_q}); end
        cycle();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL q0_after_bad: got %b want 0", mismatch); end
    endtask

    task automatic test_saturate();
        s = 1'b1; r = 1'b1;
        repeat (253) cycle();
        checks++; if (illegal_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d want 254", illegal_cnt); end
        repeat (47) cycle();
        checks++; if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", illegal_cnt); end
        clr = 1'b1; cycle();
        clr = 1'b0;
        checks++; if (illegal_cnt !== 8'd1) begin errors++; $display("FAIL clr_event_cnt: got %0d want 1", illegal_cnt); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL clr_event_sticky: got %b want 1", err_sticky); end
        checks++; if (mismatch_cnt !== 8'd0) begin errors++; $display("FAIL clr_mcnt: got %0d want 0", mismatch_cnt); end
        s = 1'b0; r = 1'b0;
    endtask

    task automatic test_async_reset();
        s = 1'b1; cycle();
        s = 1'b0; cycle();
        checks++; if ({known, model_q, illegal_cnt} !== {2'b11, 8'd1}) begin errors++; $display("FAIL pre_rst: got %b/%0d want 11/1", {known, model_q}, illegal_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({known, model_q, illegal, mismatch, err_sticky} !== 5'b00000) begin errors++; $display("FAIL async_flags: got %b want 00000", {known, model_q, illegal, mismatch, err_sticky}); end
        checks++; if ({illegal_cnt, mismatch_cnt} !== 16'h0000) begin errors++; $display("FAIL async_cnts: got %h want 0000", {illegal_cnt, mismatch_cnt}); end
        #1 rst = 1'b0;
        s = 1'b1; cycle();
        s = 1'b0;
        checks++; if ({known, model_q} !== 2'b11) begin errors++; $display("FAIL post_rst_set: got %b want 11", {known, model_q}); end
    endtask

    initial begin
        test_reset();
        test_set();
        test_mismatch();
        test_illegal();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
